dmadd_sequencer: RTL and testbench

- Command-side initiator for the delta-MADD accumulator core. It takes jobs from an upstream valid/ready stream and turns each job into the core's clear / initialise / load / run bus sequence.
- After the run phase it captures the core's 12-bit result ({out_top,out}) and returns it on a valid/ready response port.
- It sits between the host/SPI command front-end and the core, so software never has to hand-drive the core's pin-level protocol.

---
 rtl/dmadd_sequencer_if.sv | 25 ++
 rtl/dmadd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_dmadd_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmadd_sequencer_if.sv
// Host-side command and response streams of the delta-MADD sequencer.
// Both streams are valid/ready: a beat transfers on a posedge where valid and ready are both high.
// The sender holds valid and its payload stable until that transfer happens.
interface dmadd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_index;
    logic [3:0]  cmd_data;
    logic        cmd_last;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_index, cmd_data, cmd_last, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/dmadd_sequencer.sv
// Turns host jobs into the delta-MADD core's clear/init/load/run bus sequence.
// It then returns the captured 12-bit core result on the response stream.
module dmadd_sequencer #(
    parameter int unsigned RUN_CYCLES = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmadd_sequencer_if.slave     host,
    output logic                 busy_o,
    output logic                 core_rst_n_o,
    output logic [1:0]           core_insn_o,
    output logic                 core_load_o,
    output logic                 core_run_o,
    output logic [3:0]           core_index_o,
    output logic [3:0]           core_data_o,
    input  logic [7:0]           core_out_i,
    input  logic [3:0]           core_out_top_i,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_INIT    = 3'd2,
        S_LOAD    = 3'd3,
        S_RUN     = 3'd4,
        S_CAPTURE = 3'd5,
        S_ERR     = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    localparam logic [1:0] OP_MADD    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;
    localparam logic [7:0] RUN_LAST   = 8'(RUN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [11:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;
    logic        busy_q, busy_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic [1:0]  core_insn_q, core_insn_d;
    logic        core_load_q, core_load_d;
    logic        core_run_q, core_run_d;
    logic [3:0]  core_index_q, core_index_d;
    logic [3:0]  core_data_q, core_data_d;
    logic        accept;

    assign accept = host.cmd_valid & cmd_ready_q;

    // Every output is a register: the next-state logic also computes the
    // output values that belong to the state being entered.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = 1'b0;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        core_insn_d  = core_insn_q;
        core_load_d  = 1'b0;
        core_run_d   = 1'b0;
        core_index_d = core_index_q;
        core_data_d  = core_data_q;

        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    op_d = host.cmd_op;
                    if (host.cmd_op == OP_ILLEGAL) begin
                        state_d     = S_ERR;
                        cmd_ready_d = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                core_insn_d = op_q;
                if (op_q == OP_MADD) begin
                    state_d     = S_LOAD;
                    cmd_ready_d = 1'b1;
                    last_d      = 1'b0;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                core_insn_d = op_q;
                state_d     = S_LOAD;
                cmd_ready_d = 1'b1;
                last_d      = 1'b0;
            end
            S_LOAD: begin
                core_insn_d = op_q;
                // last_q marks the load cycle of the final beat; RUN follows it.
                if (last_q) begin
                    state_d    = S_RUN;
                    cnt_d      = RUN_LAST;
                    core_run_d = 1'b1;
                end else if (accept) begin
                    core_load_d  = 1'b1;
                    core_index_d = host.cmd_index;
                    core_data_d  = host.cmd_data;
                    if (host.cmd_last) begin
                        last_d = 1'b1;
                    end else begin
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                core_insn_d = op_q;
                if (cnt_q == 8'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d      = cnt_q - 8'd1;
                    core_run_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d     = S_RESP;
                res_valid_d = 1'b1;
                res_data_d  = {core_out_top_i, core_out_i};
                res_err_d   = 1'b0;
            end
            S_ERR: begin
                if (accept && host.cmd_last) begin
                    state_d     = S_RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = 12'd0;
                    res_err_d   = 1'b1;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_RESP: begin
                if (host.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_n_d = (state_d != S_CLEAR);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            last_q       <= 1'b0;
            cnt_q        <= 8'd0;
            cmd_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 12'd0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            core_insn_q  <= 2'b00;
            core_load_q  <= 1'b0;
            core_run_q   <= 1'b0;
            core_index_q <= 4'd0;
            core_data_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
            core_rst_n_q <= core_rst_n_d;
            core_insn_q  <= core_insn_d;
            core_load_q  <= core_load_d;
            core_run_q   <= core_run_d;
            core_index_q <= core_index_d;
            core_data_q  <= core_data_d;
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;
    assign host.res_err   = res_err_q;
    assign busy_o         = busy_q;
    assign core_rst_n_o   = core_rst_n_q;
    assign core_insn_o    = core_insn_q;
    assign core_load_o    = core_load_q;
    assign core_run_o     = core_run_q;
    assign core_index_o   = core_index_q;
    assign core_data_o    = core_data_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Directed bench for dmadd_sequencer with a small behavioural model of the core.
// The model keeps min/max of loaded indices or the sum of index*data products.
module tb_dmadd_sequencer;
    localparam int R = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmadd_sequencer_if bus ();

    logic        busy, core_rst_n, core_load, core_run;
    logic [1:0]  core_insn;
    logic [3:0]  core_index, core_data, core_out_top;
    logic [7:0]  core_out;
    logic [2:0]  state;

    dmadd_sequencer #(.RUN_CYCLES(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host           (bus),
        .busy_o         (busy),
        .core_rst_n_o   (core_rst_n),
        .core_insn_o    (core_insn),
        .core_load_o    (core_load),
        .core_run_o     (core_run),
        .core_index_o   (core_index),
        .core_data_o    (core_data),
        .core_out_i     (core_out),
        .core_out_top_i (core_out_top),
        .state_o        (state)
    );

    // Core model
    logic [11:0] acc;
    logic        first;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            acc   <= 12'd0;
            first <= 1'b1;
        end else if (core_load) begin
            first <= 1'b0;
            case (core_insn)
                2'b00:   acc <= (first || {8'd0, core_index} < acc) ? {8'd0, core_index} : acc;
                2'b01:   acc <= (first || {8'd0, core_index} > acc) ? {8'd0, core_index} : acc;
                2'b10:   acc <= acc + ({8'd0, core_index} * {8'd0, core_data});
                default: acc <= acc;
            endcase
        end
    end
    assign core_out     = acc[7:0];
    assign core_out_top = acc[11:8];

    // Bus monitor: samples the values held during each clock cycle
    int         cyc = 0, load_cnt = 0, run_cnt = 0, both_cnt = 0, insn_bad = 0;
    int         clr_cnt = 0, resp_cyc = 0, streak = 0, last_streak = 0;
    logic [1:0] mon_op = 2'b00;
    logic [1:0] post_clr_insn = 2'b00;
    logic       prev_rstn = 1'b0;
    logic [7:0] load_q[$];
    logic [11:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_load) begin
            load_cnt <= load_cnt + 1;
            load_q.push_back({core_index, core_data});
        end
        if (core_run) run_cnt <= run_cnt + 1;
        if (core_load && core_run) both_cnt <= both_cnt + 1;
        if ((core_load || core_run) && core_insn != mon_op) insn_bad <= insn_bad + 1;
        if (!core_rst_n && rst_n) clr_cnt <= clr_cnt + 1;
        if (core_rst_n && !prev_rstn && busy) post_clr_insn <= core_insn;
        prev_rstn <= core_rst_n;
        if (core_run) begin
            streak <= streak + 1;
        end else if (streak != 0) begin
            last_streak <= streak;
            streak      <= 0;
        end
        if (bus.res_valid) resp_cyc <= resp_cyc + 1;
    end

    int n_vec = 0;
    int n_miss = 0;
    int start_cyc = 0;
    logic [3:0] b_idx[32];
    logic [3:0] b_dat[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_res_data"},  32'(bus.res_data), 0);
        check({tag, "_res_err"},   32'(bus.res_err), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_core_rst_n"},32'(core_rst_n), 0);
        check({tag, "_core_insn"}, 32'(core_insn), 0);
        check({tag, "_core_load"}, 32'(core_load), 0);
        check({tag, "_core_run"},  32'(core_run), 0);
        check({tag, "_core_index"},32'(core_index), 0);
        check({tag, "_core_data"}, 32'(core_data), 0);
        check({tag, "_state"},     32'(state), 0);
    endtask

    // Drives n beats from b_idx/b_dat; called on a negedge. Non-first beats carry op 11.
    task automatic send_job(input logic [1:0] op, input int n, input bit gap);
        int t;
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = (i == 0) ? op : 2'b11;
            bus.cmd_index = b_idx[i];
            bus.cmd_data  = b_dat[i];
            bus.cmd_last  = (i == n - 1);
            t = 0;
            while (!bus.cmd_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("beat_ready", 32'(bus.cmd_ready), 1);
            @(negedge clk);
            if (gap && i != n - 1) begin
                bus.cmd_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
    endtask

    task automatic do_job(input string tag, input logic [1:0] op, input int n, input bit gap,
                          input logic [11:0] exp_data, input int exp_lat);
        int t, lat, l0, r0, b0, i0, c0;
        logic [11:0] exp_d;
        logic [7:0]  ld;
        bit          err;
        err = (op == 2'b11);
        exp_q.push_back(exp_data);
        mon_op = op;
        load_q.delete();
        l0 = load_cnt; r0 = run_cnt; b0 = both_cnt; i0 = insn_bad; c0 = clr_cnt;
        send_job(op, n, gap);
        t = 0;
        while (!bus.res_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_res_valid"}, 32'(bus.res_valid), 1);
        lat = cyc - start_cyc - 1;
        exp_d = exp_q.pop_front();
        check({tag, "_res_data"}, 32'(bus.res_data), 32'(exp_d));
        check({tag, "_res_err"}, 32'(bus.res_err), 32'(err));
        check({tag, "_busy"}, 32'(busy), 1);
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_loads"}, 32'(load_cnt - l0), err ? 0 : 32'(n));
        check({tag, "_runs"}, 32'(run_cnt - r0), err ? 0 : 32'(R));
        check({tag, "_clears"}, 32'(clr_cnt - c0), err ? 0 : 1);
        check({tag, "_load_and_run"}, 32'(both_cnt - b0), 0);
        check({tag, "_insn"}, 32'(insn_bad - i0), 0);
        if (!err) begin
            check({tag, "_run_streak"}, 32'(last_streak), 32'(R));
            check({tag, "_post_clear_insn"}, 32'(post_clr_insn), 32'(op));
            for (int i = 0; i < n; i++) begin
                ld = (load_q.size() != 0) ? load_q.pop_front() : 8'hxx;
                check({tag, "_load_beat"}, 32'(ld), 32'({b_idx[i], b_dat[i]}));
            end
        end
        if (!bus.res_ready) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(bus.res_valid), 1);
                check({tag, "_hold_data"}, 32'(bus.res_data), 32'(exp_d));
            end
            bus.res_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_res_drop"}, 32'(bus.res_valid), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int t, r0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_index = 4'd0;
        bus.cmd_data  = 4'd0;
        bus.cmd_last  = 1'b0;
        bus.res_ready = 1'b1;

        // Reset
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_core_rst_n", 32'(core_rst_n), 1);
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_res_valid", 32'(bus.res_valid), 0);

        // MIN 5,9 back-to-back
        b_idx[0] = 4'd5; b_dat[0] = 4'd1;
        b_idx[1] = 4'd9; b_dat[1] = 4'd6;
        do_job("min", 2'b00, 2, 1'b0, 12'h005, 4 + 2 + R);

        // MAX same beats
        do_job("max", 2'b01, 2, 1'b0, 12'h009, 4 + 2 + R);

        // MADD (3,2),(7,4): 6 + 28
        b_idx[0] = 4'd3; b_dat[0] = 4'd2;
        b_idx[1] = 4'd7; b_dat[1] = 4'd4;
        do_job("madd", 2'b10, 2, 1'b0, 12'h022, 3 + 2 + R);

        // MADD with valid toggling: 3 x 15*15 = 675
        for (int i = 0; i < 3; i++) begin
            b_idx[i] = 4'hf; b_dat[i] = 4'hf;
        end
        do_job("madd_gap", 2'b10, 3, 1'b1, 12'h2a3, -1);

        // Illegal op, 3 beats
        b_idx[0] = 4'd1; b_idx[1] = 4'd2; b_idx[2] = 4'd3;
        do_job("illegal", 2'b11, 3, 1'b0, 12'h000, -1);

        // Single-beat job
        b_idx[0] = 4'd11; b_dat[0] = 4'd0;
        do_job("single", 2'b01, 1, 1'b0, 12'h00b, 4 + 1 + R);

        // 18 beats, indices alias past 16
        for (int i = 0; i < 18; i++) begin
            b_idx[i] = 4'(i); b_dat[i] = 4'(i + 3);
        end
        do_job("long", 2'b01, 18, 1'b0, 12'h00f, 4 + 18 + R);

        // Response held for 10 cycles
        b_idx[0] = 4'd2;  b_dat[0] = 4'd0;
        b_idx[1] = 4'd12; b_dat[1] = 4'd0;
        bus.res_ready = 1'b0;
        do_job("stall", 2'b01, 2, 1'b0, 12'h00c, 4 + 2 + R);

        // Reset during RUN
        b_idx[0] = 4'd8; b_dat[0] = 4'd0;
        b_idx[1] = 4'd4; b_dat[1] = 4'd0;
        mon_op = 2'b00;
        send_job(2'b00, 2, 1'b0);
        t = 0;
        while (!core_run && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_run", 32'(core_run), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        check("abort_core_rst_n_held", 32'(core_rst_n), 0);
        rst_n = 1'b1;
        r0 = resp_cyc;
        repeat (40) @(negedge clk);
        check("abort_no_response", 32'(resp_cyc - r0), 0);
        check("abort_idle", 32'(busy), 0);

        // Next job after abort
        b_idx[0] = 4'd7; b_dat[0] = 4'd0;
        b_idx[1] = 4'd3; b_dat[1] = 4'd0;
        do_job("after_abort", 2'b00, 2, 1'b0, 12'h003, 4 + 2 + R);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
